// File: rtl/mult_sched.sv
// mult_sched: scheduler and sequencer for the shared iterative multiplier.
// Arbitrates MULT/MULTU requests from two issue slots (slot 0 is older and
// wins ties), runs a shift-add engine over the magnitudes, applies the sign
// in a final FIX cycle and owns the architectural HI/LO registers.
// Optional feature macro: MULT_EARLY_OUT_EN -- leave RUN as soon as the
// remaining multiplier bits are all zero.
//
// Handshake: a slot holds reqN high until it sees grantN high in the same
// cycle; the operands on aN/bN/signN are captured at the rising edge that
// ends that cycle, after which the slot may drop reqN.
module mult_sched #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic             sign0,
   input  logic             sign1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             grant0,
   output logic             grant1,
   input  logic             rd_req,
   output logic             rd_stall,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [CW-1:0]        cnt_q;
   logic                 neg_q;

   // Selected operands of the winning slot and their magnitudes.
   logic                 sel_sign;
   logic [WIDTH-1:0]     sel_a, sel_b;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic                 any_grant;
   logic                 run_done;
   logic [WIDTH-1:0]     mplier_shifted;

   // Arbitration: only in IDLE, never while reset is asserted, slot 0 first.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && (state_q == IDLE)) begin
         grant0 = req0;
         grant1 = req1 & ~req0;
      end
   end

   // Operand mux and magnitude (two's-complement negate when signed and negative).
   always_comb begin
      any_grant = grant0 | grant1;
      sel_sign  = grant0 ? sign0 : sign1;
      sel_a     = grant0 ? a0 : a1;
      sel_b     = grant0 ? b0 : b1;
      abs_a     = (sel_sign && sel_a[WIDTH-1]) ? (~sel_a + 1'b1) : sel_a;
      abs_b     = (sel_sign && sel_b[WIDTH-1]) ? (~sel_b + 1'b1) : sel_b;
   end

   // RUN termination: fixed W cycles, or earlier once no multiplier bits remain.
   always_comb begin
      mplier_shifted = mplier_q >> 1;
`ifdef MULT_EARLY_OUT_EN
      run_done = (cnt_q == CNT_LAST) || (mplier_shifted == '0);
`else
      run_done = (cnt_q == CNT_LAST);
`endif
   end

   // Next-state logic for the sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_grant) state_d = RUN;
         RUN:     if (run_done)  state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset discards any in-flight product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Shift-add datapath: load on grant, accumulate/shift in RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
      end else if (state_q == IDLE) begin
         if (any_grant) begin
            mcand_q  <= {{WIDTH{1'b0}}, abs_a};
            mplier_q <= abs_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= sel_sign & (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
         end
      end else if (state_q == RUN) begin
         if (mplier_q[0]) acc_q <= acc_q + mcand_q;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_shifted;
         cnt_q    <= cnt_q + 1'b1;
      end
   end

   // HI/LO write in FIX, with the sign applied to the magnitude product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (state_q == FIX) begin
         {hi, lo} <= neg_q ? (~acc_q + 1'b1) : acc_q;
      end
   end

   // Status outputs: busy outside IDLE, hold MFHI/MFLO while busy.
   always_comb begin
      busy     = (state_q != IDLE);
      rd_stall = rd_req & (state_q != IDLE);
   end

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed-vector bench for mult_sched with hand-computed
// products. Inputs change 1ns after the rising edge; outputs are sampled on
// the falling edge. Cycle 0 is the grant cycle of each multiply.
module tb_mult_sched;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0, req1, sign0, sign1;
   logic [W-1:0] a0, b0, a1, b1;
   logic         grant0, grant1;
   logic         rd_req, rd_stall, busy;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   mult_sched #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .sign0(sign0), .sign1(sign1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .grant0(grant0), .grant1(grant1),
      .rd_req(rd_req), .rd_stall(rd_stall), .busy(busy),
      .hi(hi), .lo(lo)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // Single comparison point: counts and reports.
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Expected total latency (grant cycle to first cycle with new HI/LO).
   function automatic int exp_latency(input logic sgn, input logic [W-1:0] b);
      int run;
      logic [W-1:0] m;
      run = W;
`ifdef MULT_EARLY_OUT_EN
      m = (sgn && b[W-1]) ? (~b + 1'b1) : b;
      run = 1;
      for (int k = 1; k < W; k++) if (m[k]) run = k + 1;
`else
      m = b;
      if (m == '1) run = W; // keeps m used in both builds
`endif
      return run + 2;
   endfunction

   // One multiply on a slot with an MFHI held in EX from cycle 1 onward.
   task automatic do_mult(input string tag, input bit slot, input logic sgn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      int n;
      int stalls;
      if (slot == 1'b0) begin req0 = 1'b1; sign0 = sgn; a0 = a; b0 = b; end
      else              begin req1 = 1'b1; sign1 = sgn; a1 = a; b1 = b; end
      @(negedge clk);
      check({tag, " grant"}, {62'd0, grant1, grant0}, slot ? 64'd2 : 64'd1);
      next_cycle();
      req0 = 1'b0;
      req1 = 1'b0;
      rd_req = 1'b1;
      n = 1;
      stalls = 0;
      forever begin
         @(negedge clk);
         if (!busy || n > 100) break;
         if (rd_stall) stalls++;
         n++;
         next_cycle();
      end
      check({tag, " latency"}, 64'(n), 64'(exp_latency(sgn, b)));
      check({tag, " stall cycles"}, 64'(stalls), 64'(exp_latency(sgn, b) - 1));
      check({tag, " stall released"}, {63'd0, rd_stall}, 64'd0);
      check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
      check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
      rd_req = 1'b0;
      next_cycle();
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      req0 = 1'b1; req1 = 1'b1; sign0 = 1'b0; sign1 = 1'b0;
      a0 = 32'd1; b0 = 32'd1; a1 = 32'd1; b1 = 32'd1;
      rd_req = 1'b1;
      repeat (2) @(negedge clk);
      check("reset grants", {62'd0, grant1, grant0}, 64'd0);
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset stall", {63'd0, rd_stall}, 64'd0);
      check("reset hilo", {hi, lo}, 64'd0);
      next_cycle();
      req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
      rst_n = 1'b1;
      next_cycle();

      // Unsigned maximum: (2^32-1)^2 = 0xFFFFFFFE_00000001.
      do_mult("umax", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      // Signed most-negative squared: 2^62.
      do_mult("smin", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      // -7 * 3 = -21.
      do_mult("neg7x3", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      // Slot 1 alone, -5 * -6 = 30.
      do_mult("s1_neg", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'd30);
      // Unsigned 0x80000000 * 2 = 2^32, operand MSB not treated as sign.
      do_mult("u_msb", 1'b1, 1'b0, 32'h8000_0000, 32'd2, 32'h1, 32'h0);
      // 0x12345678 * 0x100 = 0x12_34567800.
      do_mult("shift", 1'b0, 1'b0, 32'h1234_5678, 32'h100, 32'h12, 32'h3456_7800);

      // Reset mid-RUN: HI/LO hold 0x12/0x34567800 beforehand.
      req0 = 1'b1; sign0 = 1'b0; a0 = 32'd3; b0 = 32'd5;
      @(negedge clk);
      check("rst_mid grant", {63'd0, grant0}, 64'd1);
      next_cycle();
      req0 = 1'b0;
      repeat (9) next_cycle();
      rst_n = 1'b0;
      #1;
      check("rst_mid busy", {63'd0, busy}, 64'd0);
      check("rst_mid hilo", {hi, lo}, 64'd0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      do_mult("after_rst", 1'b0, 1'b0, 32'd3, 32'd5, 32'h0, 32'd15);

      // Simultaneous requests: 6*7 on slot 0 wins, 2*2 on slot 1 waits.
      req0 = 1'b1; sign0 = 1'b0; a0 = 32'd6; b0 = 32'd7;
      req1 = 1'b1; sign1 = 1'b0; a1 = 32'd2; b1 = 32'd2;
      @(negedge clk);
      check("sim grants c0", {62'd0, grant1, grant0}, 64'd1);
      next_cycle();
      req0 = 1'b0;
      n = 1;
      forever begin
         @(negedge clk);
         if (grant1 || n > 100) break;
         n++;
         next_cycle();
      end
      check("sim grant1 cycle", 64'(n), 64'(exp_latency(1'b0, 32'd7)));
      check("sim lo first", {32'd0, lo}, 64'd42);
      next_cycle();
      req1 = 1'b0;
      n = 1;
      forever begin
         @(negedge clk);
         if (!busy || n > 100) break;
         n++;
         next_cycle();
      end
      check("sim second latency", 64'(n), 64'(exp_latency(1'b0, 32'd2)));
      check("sim lo second", {32'd0, lo}, 64'd4);
      check("sim hi second", {32'd0, hi}, 64'd0);
      next_cycle();

`ifdef MULT_EARLY_OUT_EN
      // Early-out: 9*1 finishes after one RUN cycle.
      do_mult("eo_b1", 1'b0, 1'b0, 32'd9, 32'd1, 32'h0, 32'd9);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
